// File: rtl/entry_buffer_ctrl.sv
// Entry buffer controller: bs-entry store with a valid vector, lowest-free-slot allocation and victim eviction.
// Latency: plain writes and invalidates take one cycle. A write to a full buffer takes at least 2 cycles (IDLE -> EVICT -> IDLE).
// Backpressure: wr_ready drops for the whole EVICT phase, and EVICT holds until the consumer raises ev_ready.
module entry_buffer_ctrl #(
  parameter int bs = 16,
  parameter int dw = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  input  logic [dw-1:0]          wr_data,
  output logic                   wr_ready,
  input  logic                   inv_valid,
  input  logic [$clog2(bs)-1:0]  inv_index,
  input  logic [$clog2(bs)-1:0]  victim_index,
  output logic [bs-1:0]          cand_list,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [dw-1:0]          ev_data,
  output logic [$clog2(bs)-1:0]  ev_index,
  output logic [$clog2(bs):0]    occupancy,
  output logic                   full
);

  localparam int iw = $clog2(bs);
  localparam int ow = iw + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_EVICT = 1'b1
  } state_t;

  // Architectural state
  state_t          r_state;
  logic [dw-1:0]   r_mem [bs];
  logic [bs-1:0]   r_valid;
  logic [ow-1:0]   r_occ;
  logic            r_ev_valid;
  logic [dw-1:0]   r_ev_data;
  logic [iw-1:0]   r_ev_index;
  logic [dw-1:0]   r_hold;

  // Decoded controls
  logic            w_idle;
  logic            w_full;
  logic            w_inv_hit;
  logic            w_wr_acc;
  logic            w_wr_free;
  logic            w_wr_replace;
  logic            w_start_ev;
  logic            w_ev_done;
  logic            w_inv_do;
  logic [iw-1:0]   w_free_idx;
  logic [bs-1:0]   w_ev_mask;
  logic [bs-1:0]   w_valid_nxt;
  logic            w_mem_we;
  logic [iw-1:0]   w_mem_addr;
  logic [dw-1:0]   w_mem_wdata;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_full    = (r_occ == ow'(bs));
  assign w_inv_hit = inv_valid && r_valid[inv_index];

  // A write is only offered to the store while idle. A full buffer either
  // recycles the slot being invalidated in the same cycle or starts an eviction.
  assign w_wr_acc     = w_idle && wr_valid;
  assign w_wr_free    = w_wr_acc && !w_full;
  assign w_wr_replace = w_wr_acc && w_full && w_inv_hit;
  assign w_start_ev   = w_wr_acc && w_full && !w_inv_hit;
  assign w_ev_done    = !w_idle && ev_ready;

  // An invalidate clears its bit unless the same slot is being overwritten in
  // place (full + write) or is the slot currently being evicted.
  assign w_inv_do = w_inv_hit &&
                    (w_idle ? !w_wr_replace : (inv_index != r_ev_index));

  // Lowest-index invalid slot, taken from the pre-invalidate valid vector
  always_comb begin
    w_free_idx = '0;
    for (int i = bs - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_idx = iw'(i);
      end
    end
  end

  // Next valid vector: a set for the allocated slot and a clear for the invalidated slot
  always_comb begin
    w_valid_nxt = r_valid;
    if (w_wr_free) begin
      w_valid_nxt[w_free_idx] = 1'b1;
    end
    if (w_inv_do) begin
      w_valid_nxt[inv_index] = 1'b0;
    end
  end

  // Single memory write port shared by allocation, in-place replacement and eviction refill
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (w_wr_free) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = w_free_idx;
      w_mem_wdata = wr_data;
    end else if (w_wr_replace) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = inv_index;
      w_mem_wdata = wr_data;
    end else if (w_ev_done) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_ev_index;
      w_mem_wdata = r_hold;
    end
  end

  // Payload storage. It is not reset because the valid vector qualifies every entry.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // Valid vector and occupancy. The count saturates at both ends, so a stray
  // update can never wrap it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_occ   <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      if (w_wr_free && !w_inv_do && (r_occ != ow'(bs))) begin
        r_occ <= r_occ + ow'(1);
      end else if (w_inv_do && !w_wr_free && (r_occ != '0)) begin
        r_occ <= r_occ - ow'(1);
      end
    end
  end

  // IDLE/EVICT state machine with registered eviction outputs and the parked write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_ev_valid <= 1'b0;
      r_ev_data  <= '0;
      r_ev_index <= '0;
      r_hold     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_ev) begin
            r_hold     <= wr_data;
            r_ev_index <= victim_index;
            r_ev_data  <= r_mem[victim_index];
            r_ev_valid <= 1'b1;
            r_state    <= ST_EVICT;
          end
        end
        ST_EVICT: begin
          if (ev_ready) begin
            r_ev_valid <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_ev_valid <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  // The slot being evicted is withheld from the candidate list
  assign w_ev_mask = w_idle ? '0 : (bs'(1) << r_ev_index);

  assign wr_ready  = w_idle;
  assign cand_list = r_valid & ~w_ev_mask;
  assign ev_valid  = r_ev_valid;
  assign ev_data   = r_ev_data;
  assign ev_index  = r_ev_index;
  assign occupancy = r_occ;
  assign full      = w_full;

endmodule

// File: doc/entry_buffer_ctrl.md
ENTRY_BUFFER_CTRL -- requirements
Module: entry_buffer_ctrl

Interface
REQ-001 Parameter bs, default 16, number of buffer entries, a power of two, at least 2.
REQ-002 Parameter dw, default 32, entry data width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 wr_valid  input  1  write request.
REQ-006 wr_data  input  dw  write payload.
REQ-007 wr_ready  output  1  write accepted when wr_valid and wr_ready are both high at a rising edge.
REQ-008 inv_valid  input  1  invalidate request.
REQ-009 inv_index  input  $clog2(bs)  entry to invalidate.
REQ-010 victim_index  input  $clog2(bs)  randomly chosen victim index from the downstream mapping table.
REQ-011 cand_list  output  bs  eviction-candidate bitmap that feeds the mapping table.
REQ-012 ev_valid  output  1  evicted entry presented.
REQ-013 ev_ready  input  1  consumer takes the evicted entry.
REQ-014 ev_data  output  dw  evicted payload.
REQ-015 ev_index  output  $clog2(bs)  slot being evicted.
REQ-016 occupancy  output  $clog2(bs)+1  count of valid entries.
REQ-017 full  output  1  high when occupancy equals bs.

Function
REQ-018 Storage: bs x dw memory plus a bs-bit valid vector.
REQ-019 State machine: two states, IDLE and EVICT.
REQ-020 wr_ready shall equal 1 in IDLE and 0 in EVICT, driven combinationally from the state.
REQ-021 IDLE, accepted write, not full: wr_data goes to the lowest-index invalid slot, that valid bit is set, occupancy increments; this takes one cycle.
REQ-022 IDLE, accepted write, full, no qualifying invalidate:
  - wr_data is latched into a hold register.
  - ev_index is loaded with victim_index.
  - ev_data is loaded with mem[victim_index].
  - The next state is EVICT.
REQ-023 EVICT:
  - ev_valid is 1.
  - ev_data and ev_index are held stable until ev_ready is high at an edge.
  - At that edge, mem[ev_index] takes the hold register and the next state is IDLE.
  - occupancy and the valid vector are unchanged.
REQ-024 An eviction costs at least 2 cycles; a write can be accepted again in the cycle after the handshake completes.
REQ-025 IDLE, inv_valid high, target valid: the target valid bit clears and occupancy decrements.
REQ-026 inv_valid with an already-invalid target shall be ignored.
REQ-027 IDLE, simultaneous not-full write and invalidate:
  - The write slot is chosen from the pre-invalidate valid vector.
  - Both updates take effect and occupancy is unchanged.
REQ-028 IDLE, full, simultaneous write and invalidate of a valid entry:
  - wr_data is written directly into inv_index and the valid bit stays set.
  - There is no eviction and occupancy is unchanged.
REQ-029 EVICT, inv_valid with inv_index equal to ev_index shall be ignored; other indices are invalidated as in REQ-025.
REQ-030 cand_list shall equal the valid vector with bit ev_index masked while in EVICT; it is combinational from registers.
REQ-031 ev_valid shall be 0 in IDLE; ev_data and ev_index hold their last values.
REQ-032 occupancy shall never exceed bs or wrap below 0.

Reset
REQ-033 While rst is low, the block shall reset asynchronously to the following values:
  - state IDLE, valid vector 0, occupancy 0, full 0;
  - ev_valid 0, ev_data 0, ev_index 0, hold register 0;
  - wr_ready 1, cand_list 0.
REQ-034 Memory contents need not be cleared.
REQ-035 Reset during EVICT shall discard the held write and the pending eviction, and the next state after reset is IDLE.

Verification
REQ-036 Fill: bs=16, 16 writes of data 0x100+i with no gaps -> slots 0..15 filled in order; occupancy=16; full=1; cand_list=0xFFFF.
REQ-037 Evict: full buffer, victim_index=5, write 0xAAAA, ev_ready held low 3 cycles then high -> ev_valid high 4 cycles with ev_index=5 and ev_data=0x105; cand_list=0xFFDF during EVICT; afterwards mem[5]=0xAAAA, wr_ready=1, occupancy=16.
REQ-038 Gap reuse: invalidate 3 and 7, then 2 writes -> slot 3 is filled first, then slot 7; occupancy goes 14 to 16.
REQ-039 Full, simultaneous write 0xBEEF and invalidate of 9 -> mem[9]=0xBEEF, ev_valid never asserts, occupancy=16.
REQ-040 Async reset asserted mid-EVICT, between clock edges -> ev_valid=0 and occupancy=0 before the next edge; the first write after release goes to slot 0.
REQ-041 Invalidate of an already-invalid entry, and invalidate of ev_index during EVICT -> occupancy and the valid vector are unchanged.
